// File: rtl/core_port_scheduler.sv
// core_port_scheduler: arbitrates inject/eject tokens onto the shared Hamming codec and tracks router credits.
// Define SCHED_STATS_EN to add per-direction delivery counters with a synchronous clear.
module core_port_scheduler #(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inj_valid,
    output logic        inj_ready,
    input  logic        ej_valid,
    output logic        ej_ready,
    output logic        codec_start,
    output logic        codec_mode,
    input  logic        codec_done,
    output logic        rtr_valid,
    input  logic        rtr_ready,
    output logic        bkt_valid,
    input  logic        bkt_ready,
    input  logic        credit_ret,
    output logic [3:0]  credits,
`ifdef SCHED_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] inj_count,
    output logic [15:0] ej_count,
`endif
    output logic        err_timeout
);
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);
    localparam logic [7:0] TMO      = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, DELIVER} state_t;

    state_t     state, state_nxt;
    logic       sel, sel_nxt;
    logic       last_grant, last_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] credits_nxt;
    logic       err_nxt;
    logic       inj_elig, delivered, rtr_fire;

    // sel: 0 = inject/encode, 1 = eject/decode
    assign inj_elig  = inj_valid && (credits != 4'd0);
    assign delivered = (state == DELIVER) && (sel ? bkt_ready : rtr_ready);
    assign rtr_fire  = delivered && !sel;

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        last_nxt    = last_grant;
        cnt_nxt     = cnt;
        err_nxt     = err_timeout;
        inj_ready   = 1'b0;
        ej_ready    = 1'b0;
        codec_start = 1'b0;
        codec_mode  = (state != IDLE) && sel;
        rtr_valid   = (state == DELIVER) && !sel;
        bkt_valid   = (state == DELIVER) && sel;
        case (state)
            IDLE: begin
                if (inj_elig || ej_valid) begin
                    state_nxt = GRANT;
                    sel_nxt   = (inj_elig && ej_valid) ? !last_grant : ej_valid;
                end
            end
            GRANT: begin
                inj_ready   = !sel;
                ej_ready    = sel;
                codec_start = 1'b1;
                last_nxt    = sel;
                cnt_nxt     = 8'd1;
                state_nxt   = BUSY;
            end
            BUSY: begin
                cnt_nxt = cnt + 8'd1;
                // done on the timeout cycle still completes the transaction
                if (codec_done) begin
                    state_nxt = DELIVER;
                end else if (cnt == TMO) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            DELIVER: begin
                if (delivered) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign credits_nxt = (rtr_fire && credit_ret) ? credits :
                         rtr_fire ? credits - 4'd1 :
                         (credit_ret && credits < CRED_MAX) ? credits + 4'd1 : credits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= 8'd0;
            credits     <= CRED_MAX;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            last_grant  <= last_nxt;
            cnt         <= cnt_nxt;
            credits     <= credits_nxt;
            err_timeout <= err_nxt;
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_count <= 16'd0;
            ej_count  <= 16'd0;
        end else if (stats_clr) begin
            inj_count <= 16'd0;
            ej_count  <= 16'd0;
        end else if (delivered) begin
            inj_count <= inj_count + {15'd0, !sel};
            ej_count  <= ej_count + {15'd0, sel};
        end
    end
`endif
endmodule

// File: tb/tb_core_port_scheduler.sv
// tb_core_port_scheduler: randomized transactions against a transaction-level model of the scheduler.
module tb_core_port_scheduler;
    localparam int CREDITS = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0, rst_n = 1'b1;
    logic inj_valid = 1'b0, ej_valid = 1'b0, codec_done = 1'b0;
    logic rtr_ready = 1'b0, bkt_ready = 1'b0, credit_ret = 1'b0;
    logic inj_ready, ej_ready, codec_start, codec_mode, rtr_valid, bkt_valid, err_timeout;
    logic [3:0] credits;
`ifdef SCHED_STATS_EN
    logic stats_clr = 1'b0;
    logic [15:0] inj_count, ej_count;
`endif

    int checks = 0, errors = 0;
    int m_credits;
    bit m_last, m_err;
    int m_inj, m_ej;

    core_port_scheduler #(.CREDITS(CREDITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .inj_valid(inj_valid), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_ready(ej_ready),
        .codec_start(codec_start), .codec_mode(codec_mode), .codec_done(codec_done),
        .rtr_valid(rtr_valid), .rtr_ready(rtr_ready),
        .bkt_valid(bkt_valid), .bkt_ready(bkt_ready),
        .credit_ret(credit_ret), .credits(credits),
`ifdef SCHED_STATS_EN
        .stats_clr(stats_clr), .inj_count(inj_count), .ej_count(ej_count),
`endif
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_credits = CREDITS;
        m_last    = 1'b1;
        m_err     = 1'b0;
        m_inj     = 0;
        m_ej      = 0;
    endtask

    task automatic check_stats();
`ifdef SCHED_STATS_EN
        check("inj_count", int'(inj_count), m_inj & 16'hFFFF);
        check("ej_count", int'(ej_count), m_ej & 16'hFFFF);
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_inj_ready"}, int'(inj_ready), 0);
        check({tag, "_ej_ready"}, int'(ej_ready), 0);
        check({tag, "_start"}, int'(codec_start), 0);
        check({tag, "_mode"}, int'(codec_mode), 0);
        check({tag, "_rtr_valid"}, int'(rtr_valid), 0);
        check({tag, "_bkt_valid"}, int'(bkt_valid), 0);
    endtask

    // one credit_ret pulse in IDLE; a stray codec_done alongside must be ignored
    task automatic idle_ret();
        credit_ret = 1'b1;
        codec_done = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        codec_done = 1'b0;
        if (m_credits < CREDITS) m_credits++;
        check("idle_ret_credits", int'(credits), m_credits);
        check_quiet("idle");
    endtask

    // dly outside 1..TIMEOUT means the codec never answers
    task automatic txn(input bit iv, input bit ev, input int dly, input int rdy_wait,
                       input bit ret_hs, input bit ret_busy);
        bit ie, es;
        int n;
        ie = iv && (m_credits != 0);
        inj_valid = iv;
        ej_valid  = ev;
        if (!ie && !ev) begin
            repeat (3) begin
                @(negedge clk);
                check("no_grant", int'(codec_start | inj_ready | ej_ready), 0);
            end
            inj_valid = 1'b0;
            ej_valid  = 1'b0;
            check("credits_blocked", int'(credits), m_credits);
            return;
        end
        es = (ie && ev) ? !m_last : ev;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!codec_start && n < 5);
        check("grant_seen", int'(codec_start), 1);
        if (!codec_start) begin
            inj_valid = 1'b0;
            ej_valid  = 1'b0;
            return;
        end
        check("grant_latency", n, 1);
        check("grant_inj_ready", int'(inj_ready), int'(!es));
        check("grant_ej_ready", int'(ej_ready), int'(es));
        check("grant_mode", int'(codec_mode), int'(es));
        m_last    = es;
        inj_valid = 1'b0;
        ej_valid  = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            check("busy_no_offer", int'(rtr_valid | bkt_valid | codec_start), 0);
            check("busy_err", int'(err_timeout), int'(m_err));
            credit_ret = ret_busy && (k == 1);
            codec_done = (k == dly);
            if (k == dly) break;
        end
        if (ret_busy && m_credits < CREDITS) m_credits++;
        @(negedge clk);
        codec_done = 1'b0;
        credit_ret = 1'b0;
        if (dly < 1 || dly > TIMEOUT) begin
            m_err = 1'b1;
            check("timeout_err", int'(err_timeout), 1);
            check_quiet("timeout");
            check("timeout_credits", int'(credits), m_credits);
            return;
        end
        check("offer_rtr", int'(rtr_valid), int'(!es));
        check("offer_bkt", int'(bkt_valid), int'(es));
        check("deliver_mode", int'(codec_mode), int'(es));
        check("deliver_err", int'(err_timeout), int'(m_err));
        for (int w = 0; w < rdy_wait; w++) begin
            rtr_ready  = es ? 1'($urandom) : 1'b0;
            bkt_ready  = es ? 1'b0 : 1'($urandom);
            codec_done = 1'($urandom);
            @(negedge clk);
            check("hold_valid", int'(es ? bkt_valid : rtr_valid), 1);
            check("hold_credits", int'(credits), m_credits);
        end
        codec_done = 1'b0;
        rtr_ready  = !es;
        bkt_ready  = es;
        credit_ret = ret_hs;
        @(negedge clk);
        rtr_ready  = 1'b0;
        bkt_ready  = 1'b0;
        credit_ret = 1'b0;
        if (!es) begin
            if (!ret_hs) m_credits--;
            m_inj++;
        end else begin
            if (ret_hs && m_credits < CREDITS) m_credits++;
            m_ej++;
        end
        check("valid_drop", int'(rtr_valid | bkt_valid), 0);
        check("credits", int'(credits), m_credits);
        check_stats();
    endtask

    task automatic reset_busy();
        ej_valid = 1'b1;
        repeat (3) @(negedge clk);
        ej_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        check("mid_reset_credits", int'(credits), CREDITS);
        check("mid_reset_err", int'(err_timeout), 0);
        model_reset();
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset_credits", int'(credits), CREDITS);
        check("reset_err", int'(err_timeout), 0);
        check_stats();
        rst_n = 1'b1;
        @(negedge clk);
        // lone injection, then alternating contention
        txn(1, 0, 3, 0, 0, 0);
        repeat (6) txn(1, 1, $urandom_range(1, TIMEOUT), $urandom_range(0, 2), 1, 0);
        // exhaust credits; only ejection proceeds until a credit returns
        while (m_credits > 0) txn(1, 0, 2, 0, 0, 0);
        txn(1, 0, 2, 0, 0, 0);
        txn(1, 1, 2, 0, 0, 0);
        idle_ret();
        txn(1, 0, 2, 0, 0, 0);
        repeat (CREDITS + 1) idle_ret();
        // timeout, then done arriving exactly on the timeout cycle
        txn(1, 0, 0, 0, 0, 0);
        txn(0, 1, TIMEOUT, 0, 0, 0);
        txn(0, 1, 4, 5, 0, 0);
        txn(1, 0, 2, 1, 1, 0);
        txn(0, 1, 3, 0, 0, 1);
        reset_busy();
        txn(1, 0, 1, 0, 0, 0);
        txn(0, 1, 1, 0, 0, 0);
        txn(1, 1, 2, 0, 0, 0);
`ifdef SCHED_STATS_EN
        check("stats_sum", int'(inj_count) + int'(ej_count), 3);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        m_inj = 0;
        m_ej  = 0;
        check_stats();
`endif
        for (int i = 0; i < 300; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            if ($urandom_range(0, 3) == 0) idle_ret();
            txn(1'($urandom), 1'($urandom), d, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
